// File: rtl/regfile_mp_sb_if.sv
// Register-file access bundle: two read ports, two write ports,
// scoreboard set, hazard/pending status and the debug read port.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              busy1;
    logic              busy2;
    logic              hazard;
    logic [ADDR_W:0]   pend_cnt;
    logic [ADDR_W-1:0] reg_sel;
    logic [DATA_W-1:0] reg_data;

    modport master (
        output ra1, ra2,
        output we0, wa0, wd0,
        output we1, wa1, wd1,
        output sb_set, sb_addr,
        output reg_sel,
        input  rd1, rd2,
        input  busy1, busy2, hazard, pend_cnt,
        input  reg_data
    );

    modport slave (
        input  ra1, ra2,
        input  we0, wa0, wd0,
        input  we1, wa1, wd1,
        input  sb_set, sb_addr,
        input  reg_sel,
        output rd1, rd2,
        output busy1, busy2, hazard, pend_cnt,
        output reg_data
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Dual-write register file with busy scoreboard and debug port.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic              clk,
    input logic              rst,
    regfile_mp_sb_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0] regs_d;
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_d;
    logic [ADDR_W:0]              pend_q;
    logic [ADDR_W:0]              pend_d;

    logic w0_ok;
    logic w1_ok;
    logic set_ok;
    logic inc;
    logic dec;

    addr_t ra  [2];
    data_t rd  [2];
    logic  bsy [2];

    function automatic logic is_zero(input addr_t a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        w0_ok  = bus.we0 && !is_zero(bus.wa0);
        w1_ok  = bus.we1 && !is_zero(bus.wa1) &&
                 !(bus.we0 && (bus.wa0 == bus.wa1));
        set_ok = bus.sb_set && !is_zero(bus.sb_addr);

        regs_d = regs_q;
        if (w1_ok) regs_d[bus.wa1] = bus.wd1;
        if (w0_ok) regs_d[bus.wa0] = bus.wd0;

        // Set after clear: a freshly issued op outranks a completion.
        busy_d = busy_q;
        if (bus.we1) busy_d[bus.wa1] = 1'b0;
        if (set_ok)  busy_d[bus.sb_addr] = 1'b1;

        inc = set_ok && !busy_q[bus.sb_addr];
        dec = bus.we1 && busy_q[bus.wa1] &&
              !(set_ok && (bus.sb_addr == bus.wa1));

        pend_d = pend_q + {{ADDR_W{1'b0}}, inc}
                        - {{ADDR_W{1'b0}}, dec};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '0;
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p]  = regs_q[ra[p]];
            bsy[p] = busy_q[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (w0_ok && (bus.wa0 == ra[p])) begin
                rd[p] = bus.wd0;
            end else if (w1_ok && (bus.wa1 == ra[p])) begin
                rd[p] = bus.wd1;
            end
            if (bus.we1 && (bus.wa1 == ra[p]) &&
                !(set_ok && (bus.sb_addr == ra[p]))) begin
                bsy[p] = 1'b0;
            end
`endif
            if (is_zero(ra[p])) begin
                rd[p]  = '0;
                bsy[p] = 1'b0;
            end
        end
    end

    assign bus.rd1      = rd[0];
    assign bus.rd2      = rd[1];
    assign bus.busy1    = bsy[0];
    assign bus.busy2    = bsy[1];
    assign bus.hazard   = bsy[0] | bsy[1];
    assign bus.pend_cnt = pend_q;
    assign bus.reg_data = (bus.reg_sel == '0) ? '0
                                              : regs_q[bus.reg_sel];
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb.
// Works with or without REGFILE_BYPASS_EN defined.
module tb_regfile_mp_sb;
    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_mp_sb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.we0     = 1'b0;
        bus.wa0     = '0;
        bus.wd0     = '0;
        bus.we1     = 1'b0;
        bus.wa1     = '0;
        bus.wd1     = '0;
        bus.sb_set  = 1'b0;
        bus.sb_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h1234;
        tick();
        idle();
        bus.ra1 = 5'd5;
        #1;
        n_run++;
        if (bus.rd1 !== 32'h1234) begin
            n_fail++;
            $display("FAIL pre_reset_rd1: got %h want %h", bus.rd1, 32'h1234);
        end
        rst = 1'b0;
        bus.we0 = 1'b1; bus.wa0 = 5'd6; bus.wd0 = 32'h55;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd5;
        tick();
        rst = 1'b1;
        idle();
        bus.ra1 = 5'd5;
        bus.ra2 = 5'd6;
        #1;
        n_run++;
        if (bus.rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd1: got %h want 0", bus.rd1);
        end
        n_run++;
        if (bus.rd2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_write_ignored: got %h want 0", bus.rd2);
        end
        n_run++;
        if (bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_pend: got %0d want 0", bus.pend_cnt);
        end
        n_run++;
        if (bus.busy1 !== 1'b0 || bus.hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b/%b want 0/0",
                     bus.busy1, bus.hazard);
        end
    endtask

    task automatic test_basic();
        idle();
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'hDEADBEEF;
        tick();
        bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hFFFFFFFF;
        tick();
        idle();
        bus.ra1 = 5'd3;
        bus.ra2 = 5'd0;
        bus.reg_sel = 5'd3;
        #1;
        n_run++;
        if (bus.rd1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_rd1: got %h want deadbeef", bus.rd1);
        end
        n_run++;
        if (bus.rd2 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_rd2: got %h want 0", bus.rd2);
        end
        n_run++;
        if (bus.reg_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL dbg_r3: got %h want deadbeef", bus.reg_data);
        end
        bus.reg_sel = 5'd0;
        #1;
        n_run++;
        if (bus.reg_data !== 32'h0) begin
            n_fail++;
            $display("FAIL dbg_r0: got %h want 0", bus.reg_data);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] exp_byp;
        idle();
        bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h99;
        tick();
        bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
        bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
        bus.ra1 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h11;
`else
        exp_byp = 32'h99;
`endif
        n_run++;
        if (bus.rd1 !== exp_byp) begin
            n_fail++;
            $display("FAIL conflict_same_cycle: got %h want %h",
                     bus.rd1, exp_byp);
        end
        tick();
        idle();
        #1;
        n_run++;
        if (bus.rd1 !== 32'h11) begin
            n_fail++;
            $display("FAIL conflict_port0_wins: got %h want 11", bus.rd1);
        end
        n_run++;
        if (bus.pend_cnt !== 6'd0 || bus.busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL we1_not_busy: got pend %0d busy %b want 0/0",
                     bus.pend_cnt, bus.busy1);
        end
    endtask

    task automatic test_scoreboard();
        logic exp_b;
        logic [31:0] exp_d;
        idle();
        bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
        bus.ra1 = 5'd1;
        bus.ra2 = 5'd9;
        #1;
        n_run++;
        if (bus.hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_same_cycle_set: got %b want 0", bus.hazard);
        end
        tick();
        idle();
        #1;
        n_run++;
        if (bus.busy2 !== 1'b1 || bus.hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set_busy: got %b/%b want 1/1",
                     bus.busy2, bus.hazard);
        end
        n_run++;
        if (bus.pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL sb_set_pend: got %0d want 1", bus.pend_cnt);
        end
        bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'hABCD;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_b = 1'b0;
        exp_d = 32'hABCD;
`else
        exp_b = 1'b1;
        exp_d = 32'h0;
`endif
        n_run++;
        if (bus.busy2 !== exp_b || bus.rd2 !== exp_d) begin
            n_fail++;
            $display("FAIL clear_same_cycle: got %b %h want %b %h",
                     bus.busy2, bus.rd2, exp_b, exp_d);
        end
        tick();
        idle();
        #1;
        n_run++;
        if (bus.busy2 !== 1'b0 || bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL we1_clear: got busy %b pend %0d want 0/0",
                     bus.busy2, bus.pend_cnt);
        end
        n_run++;
        if (bus.rd2 !== 32'hABCD) begin
            n_fail++;
            $display("FAIL we1_data: got %h want abcd", bus.rd2);
        end
        bus.sb_set = 1'b1; bus.sb_addr = 5'd10;
        tick();
        bus.sb_set = 1'b0;
        bus.we0 = 1'b1; bus.wa0 = 5'd10; bus.wd0 = 32'h77;
        tick();
        idle();
        bus.ra1 = 5'd10;
        #1;
        n_run++;
        if (bus.busy1 !== 1'b1 || bus.rd1 !== 32'h77 ||
            bus.pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL we0_keeps_busy: got %b %h %0d want 1 77 1",
                     bus.busy1, bus.rd1, bus.pend_cnt);
        end
        bus.we1 = 1'b1; bus.wa1 = 5'd10; bus.wd1 = 32'h78;
        tick();
        idle();
        #1;
        n_run++;
        if (bus.busy1 !== 1'b0 || bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL r10_clear: got %b %0d want 0 0",
                     bus.busy1, bus.pend_cnt);
        end
    endtask

    task automatic test_set_clear();
        idle();
        bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
        tick();
        tick();
        idle();
        bus.ra1 = 5'd4;
        #1;
        n_run++;
        if (bus.pend_cnt !== 6'd1 || bus.busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL double_set_once: got %0d %b want 1 1",
                     bus.pend_cnt, bus.busy1);
        end
        bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'h44;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
        #1;
        n_run++;
        if (bus.busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL set_clear_same_cycle: got %b want 1", bus.busy1);
        end
        tick();
        idle();
        #1;
        n_run++;
        if (bus.busy1 !== 1'b1 || bus.pend_cnt !== 6'd1 ||
            bus.rd1 !== 32'h44) begin
            n_fail++;
            $display("FAIL set_wins: got %b %0d %h want 1 1 44",
                     bus.busy1, bus.pend_cnt, bus.rd1);
        end
        bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'h45;
        tick();
        idle();
        #1;
        n_run++;
        if (bus.pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL r4_release: got %0d want 0", bus.pend_cnt);
        end
    endtask

    task automatic test_count();
        logic [5:0] exp_cnt;
        idle();
        for (int i = 1; i <= 3; i++) begin
            bus.sb_set = 1'b1;
            bus.sb_addr = 5'(i);
            tick();
            exp_cnt = 6'(i);
            n_run++;
            if (bus.pend_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL count_up_%0d: got %0d want %0d",
                         i, bus.pend_cnt, exp_cnt);
            end
        end
        bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
        bus.we1 = 1'b1; bus.wa1 = 5'd2; bus.wd1 = 32'h5;
        tick();
        idle();
        bus.ra1 = 5'd0;
        bus.ra2 = 5'd2;
        #1;
        n_run++;
        if (bus.pend_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL count_r0_set: got %0d want 2", bus.pend_cnt);
        end
        n_run++;
        if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0 ||
            bus.rd2 !== 32'h5) begin
            n_fail++;
            $display("FAIL count_busy: got %b %b %h want 0 0 5",
                     bus.busy1, bus.busy2, bus.rd2);
        end
        bus.sb_set = 1'b1; bus.sb_addr = 5'd5;
        bus.we1 = 1'b1; bus.wa1 = 5'd1; bus.wd1 = 32'h6;
        tick();
        idle();
        bus.ra1 = 5'd1;
        bus.ra2 = 5'd3;
        #1;
        n_run++;
        if (bus.pend_cnt !== 6'd2 || bus.busy1 !== 1'b0 ||
            bus.busy2 !== 1'b1 || bus.hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL count_swap: got %0d %b %b %b want 2 0 1 1",
                     bus.pend_cnt, bus.busy1, bus.busy2, bus.hazard);
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.ra1 = '0;
        bus.ra2 = '0;
        bus.reg_sel = '0;
        idle();
        tick();
        tick();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_conflict();
        test_scoreboard();
        test_set_clear();
        test_count();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
